pool: RTL and testbench

//  Pooling stage directly downstream of the normalization stage; consumes its out_data/out_data_available stream.
//  - Reduces each group of POOL consecutive input vectors to one output vector, element-wise (non-overlapping windows, stride = window).
//  - Each vector holds MAT_MUL_SIZE signed elements.
//  - Output feeds the activation/output buffer stage.

---
 rtl/pool.sv | 155 +++++++++++++++
 tb/tb_pool.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pool.sv
// Element-wise non-overlapping pooling of MAT_MUL_SIZE-wide signed vectors, window 1/2/4.
// Build option AVG_POOL_EN adds input pool_avg (average pooling via arithmetic shift).
module pool #(
  parameter int DWIDTH       = 8,
  parameter int MAT_MUL_SIZE = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable_pool,
  input  logic [1:0]                     pool_window,
`ifdef AVG_POOL_EN
  input  logic                           pool_avg,
`endif
  input  logic                           in_data_available,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] inp_data,
  input  logic                           flush,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] out_data,
  output logic                           out_data_available,
  output logic                           pool_busy
);

  // state | meaning
  // IDLE  | no beats held, cnt == 0
  // ACCUM | 0 < cnt < W beats folded into acc_q

`ifdef AVG_POOL_EN
  localparam int AW = DWIDTH + 2;  // headroom for a 4-beat sum
`else
  localparam int AW = DWIDTH;
`endif

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                           state_q, state_d;
  logic [2:0]                       cnt_q, cnt_d;
  logic [1:0]                       win_q, win_d;
  logic [MAT_MUL_SIZE-1:0][AW-1:0]  acc_q, acc_d, merged;
  logic [MAT_MUL_SIZE*DWIDTH-1:0]   emit_data;
  logic                             emit;
  logic                             first;
  logic [1:0]                       win_eff;
  logic [2:0]                       wlen;
  logic [1:0]                       shift_amt;
  logic                             avg_eff;
  logic signed [AW-1:0]             beat_x;
  logic signed [AW-1:0]             res_x;

`ifdef AVG_POOL_EN
  logic avg_q, avg_d;
`endif

  assign first     = (state_q == IDLE);
  // The window size is taken live on the opening beat, from the latch afterwards.
  assign win_eff   = first ? pool_window : win_q;
  assign wlen      = win_eff[1] ? 3'd4 : (win_eff[0] ? 3'd2 : 3'd1);
  assign shift_amt = win_eff[1] ? 2'd2 : {1'b0, win_eff[0]};
  assign pool_busy = (state_q == ACCUM);

`ifdef AVG_POOL_EN
  assign avg_eff = first ? pool_avg : avg_q;
`else
  assign avg_eff = 1'b0;
`endif

  always_comb begin
    merged    = '0;
    emit_data = '0;
    beat_x    = '0;
    res_x     = '0;
    for (int i = 0; i < MAT_MUL_SIZE; i++) begin
      beat_x = AW'($signed(inp_data[i*DWIDTH +: DWIDTH]));
      if (first)
        merged[i] = beat_x;
      else if (avg_eff)
        merged[i] = acc_q[i] + beat_x;
      else if (beat_x > $signed(acc_q[i]))
        merged[i] = beat_x;
      else
        merged[i] = acc_q[i];
      res_x = in_data_available ? $signed(merged[i]) : $signed(acc_q[i]);
      if (avg_eff)
        res_x = res_x >>> shift_amt;
      emit_data[i*DWIDTH +: DWIDTH] = DWIDTH'(res_x);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    acc_d   = acc_q;
    emit    = 1'b0;
`ifdef AVG_POOL_EN
    avg_d   = avg_q;
`endif
    if (!enable_pool) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (in_data_available) begin
      if (first) begin
        win_d = pool_window;
`ifdef AVG_POOL_EN
        avg_d = pool_avg;
`endif
      end
      if ((cnt_q + 3'd1 == wlen) || flush) begin
        emit    = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        acc_d   = merged;
        cnt_d   = cnt_q + 3'd1;
        state_d = ACCUM;
      end
    end else if (flush && state_q == ACCUM) begin
      emit    = 1'b1;
      cnt_d   = '0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q            <= IDLE;
      cnt_q              <= '0;
      win_q              <= '0;
      acc_q              <= '0;
      out_data           <= '0;
      out_data_available <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      acc_q   <= acc_d;
      if (!enable_pool) begin
        out_data           <= inp_data;
        out_data_available <= in_data_available;
      end else begin
        out_data_available <= emit;
        if (emit)
          out_data <= emit_data;
      end
    end
  end

`ifdef AVG_POOL_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      avg_q <= 1'b0;
    else
      avg_q <= avg_d;
  end
`endif

endmodule

// File: tb/tb_pool.sv
// Self-checking bench for pool: queue-based reference model checked every cycle,
// plus directed windows with literal expectations.
module tb_pool;
  localparam int DW = 8;
  localparam int MS = 4;
  localparam int VW = DW * MS;
  typedef logic [VW-1:0] vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable_pool = 1'b0;
  logic [1:0] pool_window = 2'b00;
  logic       pool_avg_in = 1'b0;
  logic       in_data_available = 1'b0;
  logic       flush = 1'b0;
  vec_t       inp_data = '0;
  vec_t       out_data;
  logic       out_data_available;
  logic       pool_busy;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  vec_t q[$];
  int   win_len = 1;
  bit   win_avg = 1'b0;
  vec_t exp_out = '0;
  logic exp_stb = 1'b0;

  always #5 clk = ~clk;

  pool dut (
    .clk               (clk),
    .reset             (reset),
    .enable_pool       (enable_pool),
    .pool_window       (pool_window),
`ifdef AVG_POOL_EN
    .pool_avg          (pool_avg_in),
`endif
    .in_data_available (in_data_available),
    .inp_data          (inp_data),
    .flush             (flush),
    .out_data          (out_data),
    .out_data_available(out_data_available),
    .pool_busy         (pool_busy)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic vec_t reduce_window();
    vec_t r = '0;
    for (int i = 0; i < MS; i++) begin
      logic signed [DW-1:0] e;
      int best, sum, res;
      e = q[0][i*DW +: DW];
      best = e;
      sum = 0;
      foreach (q[j]) begin
        e = q[j][i*DW +: DW];
        if (int'(e) > best) best = e;
        sum += e;
      end
      res = win_avg ? (sum >>> $clog2(win_len)) : best;
      r[i*DW +: DW] = res[DW-1:0];
    end
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    exp_out = '0;
    exp_stb = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic [1:0] pw, input logic dav,
                            input logic fl, input vec_t d, input logic av);
    exp_stb = 1'b0;
    if (!en) begin
      exp_out = d;
      exp_stb = dav;
      q.delete();
    end else begin
      if (dav) begin
        if (q.size() == 0) begin
          win_len = (pw == 2'd0) ? 1 : (pw == 2'd1) ? 2 : 4;
          win_avg = av;
        end
        q.push_back(d);
      end
      if (q.size() > 0 && (q.size() == win_len || fl)) begin
        exp_out = reduce_window();
        exp_stb = 1'b1;
        q.delete();
      end
    end
  endtask

  task automatic cyc(input logic en, input logic [1:0] pw, input logic dav,
                     input logic fl, input vec_t d, input logic av);
    enable_pool = en;
    pool_window = pw;
    in_data_available = dav;
    flush = fl;
    inp_data = d;
    pool_avg_in = av;
    @(posedge clk);
    #1;
`ifdef AVG_POOL_EN
    model_step(en, pw, dav, fl, d, av);
`else
    model_step(en, pw, dav, fl, d, 1'b0);
`endif
  endtask

  function automatic vec_t mk(input int e0);
    vec_t v;
    v = $urandom;
    v[7:0] = e0[7:0];
    return v;
  endfunction

  task automatic idle(input logic [1:0] pw);
    cyc(1'b1, pw, 1'b0, 1'b0, $urandom, 1'b0);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_out_data", out_data, exp_out);
      chk("model_strobe", out_data_available, exp_stb);
      chk("model_busy", pool_busy, (q.size() > 0));
    end
  end

  initial begin
    #12;
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_strobe", out_data_available, 1'b0);
    chk("rst_busy", pool_busy, 1'b0);
    reset = 1'b1;
    cmp_en = 1'b1;

    // Reset mid-window after a completed window left out_data non-zero
    cyc(1'b1, 2'b00, 1'b1, 1'b0, 32'h11223344, 1'b0);
    chk("w1_pass", out_data, 32'h11223344);
    cyc(1'b1, 2'b01, 1'b1, 1'b0, mk(7), 1'b0);
    chk("rst_pre_busy", pool_busy, 1'b1);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_out", out_data, 32'h0);
    chk("rst_mid_strobe", out_data_available, 1'b0);
    chk("rst_mid_busy", pool_busy, 1'b0);
    #2 reset = 1'b1;
    cyc(1'b1, 2'b01, 1'b1, 1'b0, mk(3), 1'b0);
    cyc(1'b1, 2'b01, 1'b1, 1'b0, mk(1), 1'b0);
    chk("rst_clean_win", out_data[7:0], 8'd3);
    chk("rst_clean_stb", out_data_available, 1'b1);

    // Window 2 max
    cyc(1'b1, 2'b01, 1'b1, 1'b0, mk(5), 1'b0);
    chk("w2_mid_stb", out_data_available, 1'b0);
    cyc(1'b1, 2'b01, 1'b1, 1'b0, mk(-3), 1'b0);
    chk("w2_max_a", out_data[7:0], 8'd5);
    chk("w2_stb_a", out_data_available, 1'b1);
    chk("model_pin_w2", exp_out[7:0], 8'd5);
    cyc(1'b1, 2'b01, 1'b1, 1'b0, mk(-7), 1'b0);
    chk("w2_stb_drop", out_data_available, 1'b0);
    cyc(1'b1, 2'b01, 1'b1, 1'b0, mk(-2), 1'b0);
    chk("w2_max_b", out_data[7:0], 8'hFE);

    // Window 4 with gaps; pool_window changes mid-window are ignored
    cyc(1'b1, 2'b10, 1'b1, 1'b0, mk(1), 1'b0);
    chk("w4_busy1", pool_busy, 1'b1);
    idle(2'b00);
    chk("w4_busy_gap", pool_busy, 1'b1);
    cyc(1'b1, 2'b01, 1'b1, 1'b0, mk(9), 1'b0);
    chk("w4_no_early", out_data_available, 1'b0);
    idle(2'b00);
    cyc(1'b1, 2'b00, 1'b1, 1'b0, mk(-4), 1'b0);
    cyc(1'b1, 2'b00, 1'b1, 1'b0, mk(3), 1'b0);
    chk("w4_max", out_data[7:0], 8'd9);
    chk("w4_stb", out_data_available, 1'b1);
    chk("w4_busy_end", pool_busy, 1'b0);

    // Flush of a partial window, then flush while idle
    cyc(1'b1, 2'b11, 1'b1, 1'b0, mk(2), 1'b0);
    cyc(1'b1, 2'b11, 1'b1, 1'b0, mk(6), 1'b0);
    cyc(1'b1, 2'b11, 1'b0, 1'b1, mk(0), 1'b0);
    chk("flush_val", out_data[7:0], 8'd6);
    chk("flush_stb", out_data_available, 1'b1);
    chk("flush_busy", pool_busy, 1'b0);
    cyc(1'b1, 2'b11, 1'b0, 1'b1, mk(0), 1'b0);
    chk("flush_idle_stb", out_data_available, 1'b0);
    cyc(1'b1, 2'b10, 1'b1, 1'b1, mk(-9), 1'b0);
    chk("flush_idle_beat", out_data[7:0], 8'hF7);

    // Abort by dropping enable_pool, then bypass echo
    cyc(1'b1, 2'b01, 1'b1, 1'b0, mk(40), 1'b0);
    cyc(1'b0, 2'b01, 1'b0, 1'b0, mk(0), 1'b0);
    chk("abort_stb", out_data_available, 1'b0);
    chk("abort_busy", pool_busy, 1'b0);
    cyc(1'b0, 2'b01, 1'b1, 1'b0, mk(55), 1'b0);
    chk("bypass_val", out_data[7:0], 8'd55);
    chk("bypass_stb", out_data_available, 1'b1);
    cyc(1'b1, 2'b01, 1'b1, 1'b0, mk(-1), 1'b0);
    chk("after_bypass_stb", out_data_available, 1'b0);
    cyc(1'b1, 2'b01, 1'b1, 1'b0, mk(-8), 1'b0);
    chk("after_bypass_max", out_data[7:0], 8'hFF);

`ifdef AVG_POOL_EN
    cyc(1'b1, 2'b10, 1'b1, 1'b0, mk(4), 1'b1);
    cyc(1'b1, 2'b10, 1'b1, 1'b0, mk(8), 1'b0);
    cyc(1'b1, 2'b10, 1'b1, 1'b0, mk(-2), 1'b0);
    cyc(1'b1, 2'b10, 1'b1, 1'b0, mk(6), 1'b0);
    chk("avg_w4", out_data[7:0], 8'd4);
    cyc(1'b1, 2'b01, 1'b1, 1'b0, mk(-3), 1'b1);
    cyc(1'b1, 2'b01, 1'b1, 1'b0, mk(-4), 1'b1);
    chk("avg_w2_neg", out_data[7:0], 8'hFC);
`endif

    // Randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 99) >= 3), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 10),
          $urandom, 1'($urandom_range(0, 1)));
    end
    repeat (3) idle(2'b00);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
